// File: rtl/seg_disp_scan.sv
// seg_disp_scan: multiplexed N-digit 7-segment driver with PWM, blanking, double buffering; SEG_DISP_BLINK_EN adds per-digit blink.
module seg_disp_scan #(
  parameter int   DIGITS     = 4,
  parameter int   SLOT_WIDTH = 16,
  parameter logic AN_ACTIVE  = 1'b0,
  parameter logic SEG_ACTIVE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     dot,
`ifdef SEG_DISP_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  input  logic [3:0]            brightness,
  output logic                  pending,
  output logic                  frame_start,
  output logic [7:0]            segment,
  output logic [DIGITS-1:0]     anode
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef SEG_DISP_BLINK_EN
  localparam int BW = 7 * DIGITS;
  logic [BW-1:0] in_vec;
  logic [4:0]    frame_d, frame_q;
  assign in_vec = {blink, dot, en, data};
`else
  localparam int BW = 6 * DIGITS;
  logic [BW-1:0] in_vec;
  assign in_vec = {dot, en, data};
`endif
  logic [BW-1:0]         buf_d, buf_q, shd_d, shd_q;
  logic [SLOT_WIDTH-1:0] slot_d, slot_q;
  logic [IW-1:0]         idx_d, idx_q;
  logic                  pending_d, pending_q, frame_start_d, frame_start_q;
  logic [7:0]            segment_d, segment_q, raw;
  logic [DIGITS-1:0]     anode_d, anode_q, onehot;
  logic [3:0]            phase;
  logic                  boundary, lit, blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    boundary      = &slot_q && idx_q == IW'(DIGITS - 1);
    phase         = slot_q[SLOT_WIDTH-1 -: 4];
    slot_d        = slot_q + 1'b1;
    idx_d         = &slot_q ? (boundary ? '0 : idx_q + 1'b1) : idx_q;
    // A load on the boundary cycle bypasses straight into the shadow.
    buf_d         = load ? in_vec : buf_q;
    shd_d         = boundary ? buf_d : shd_q;
    pending_d     = !boundary && (load || pending_q);
`ifdef SEG_DISP_BLINK_EN
    frame_d       = boundary ? frame_q + 1'b1 : frame_q;
    blank         = shd_q[6*DIGITS + idx_q] && frame_q[4];
`else
    blank         = 1'b0;
`endif
    lit           = phase != 4'd0 && phase <= brightness && !blank;
    raw           = {shd_q[5*DIGITS + idx_q],
                     shd_q[4*DIGITS + idx_q] ? hex7(shd_q[4*idx_q +: 4]) : 7'h00};
    onehot        = DIGITS'(1) << idx_q;
    segment_d     = lit ? (SEG_ACTIVE ? raw : ~raw) : {8{~SEG_ACTIVE}};
    anode_d       = lit ? (AN_ACTIVE ? onehot : ~onehot) : {DIGITS{~AN_ACTIVE}};
    frame_start_d = slot_q == '0 && idx_q == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      idx_q         <= '0;
      buf_q         <= '0;
      shd_q         <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      segment_q     <= {8{~SEG_ACTIVE}};
      anode_q       <= {DIGITS{~AN_ACTIVE}};
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      shd_q         <= shd_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      segment_q     <= segment_d;
      anode_q       <= anode_d;
    end
  end

`ifdef SEG_DISP_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_q <= '0;
    else        frame_q <= frame_d;
  end
`endif

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign segment     = segment_q;
  assign anode       = anode_q;
endmodule

// File: tb/tb_seg_disp_scan.sv
// tb_seg_disp_scan: directed checks of scan timing, PWM, handshake and enables for a 4-digit, 64-cycle-slot build.
module tb_seg_disp_scan;
  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  en = '0, dot = '0, brightness = 4'd15;
`ifdef SEG_DISP_BLINK_EN
  logic [3:0]  blink = '0;
`endif
  logic        pending, frame_start;
  logic [7:0]  segment;
  logic [3:0]  anode;
  int          t = 0, n_vec = 0, n_err = 0;

  seg_disp_scan #(.DIGITS(4), .SLOT_WIDTH(6), .AN_ACTIVE(1'b0), .SEG_ACTIVE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .en(en), .dot(dot),
`ifdef SEG_DISP_BLINK_EN
    .blink(blink),
`endif
    .brightness(brightness), .pending(pending), .frame_start(frame_start),
    .segment(segment), .anode(anode));

  always #5 clk = ~clk;

  // t counts rising edges since reset; outputs seen at t reflect scan position t-1.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) t <= 0;
    else        t <= t + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at t=%0d", t);
    $fatal(1);
  end

  task automatic goto(input int k);
    do @(negedge clk); while (t < k);
    if (t != k) begin
      $display("FAIL goto: at t=%0d, required t=%0d", t, k);
      $fatal(1);
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    n_vec += 4;
    if (anode !== 4'hF)      begin n_err++; $display("FAIL rst_anode: got %h want f", anode); end
    if (segment !== 8'hFF)   begin n_err++; $display("FAIL rst_segment: got %h want ff", segment); end
    if (pending !== 1'b0)    begin n_err++; $display("FAIL rst_pending: got %b want 0", pending); end
    if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    rst_n = 1'b1;
    goto(1);
    n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_first: got %b want 1", frame_start); end
    goto(2);
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL fs_second: got %b want 0", frame_start); end
    goto(4);
    n_vec++; if (anode !== 4'hF) begin n_err++; $display("FAIL blank_phase0: got %h want f", anode); end
    goto(5);
    n_vec++; if (anode !== 4'hE) begin n_err++; $display("FAIL first_lit: got %h want e", anode); end
    goto(37);
    n_vec++; if (anode !== 4'hE) begin n_err++; $display("FAIL lit_s36: got %h want e", anode); end
    rst_n = 1'b0;
    #1;
    n_vec += 2;
    if (anode !== 4'hF)    begin n_err++; $display("FAIL midrst_anode: got %h want f", anode); end
    if (segment !== 8'hFF) begin n_err++; $display("FAIL midrst_segment: got %h want ff", segment); end
    @(negedge clk);
    rst_n = 1'b1;
    goto(4);
    n_vec++; if (anode !== 4'hF) begin n_err++; $display("FAIL rerst_c4: got %h want f", anode); end
    goto(5);
    n_vec++; if (anode !== 4'hE) begin n_err++; $display("FAIL rerst_c5: got %h want e", anode); end
  endtask

  task automatic test_load;
    logic [3:0] an_x [4];
    logic [7:0] sg_x [4];
    an_x = '{4'hE, 4'hD, 4'hB, 4'h7};
    sg_x = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    goto(10);
    load = 1'b1; data = 16'h1234; en = 4'hF; dot = 4'b0100;
    goto(11);
    load = 1'b0;
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL pend_set: got %b want 1", pending); end
    goto(255);
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL pend_hold: got %b want 1", pending); end
    goto(256);
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL pend_clear: got %b want 0", pending); end
    goto(257);
    n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_frame1: got %b want 1", frame_start); end
    for (int d = 0; d < 4; d++) begin
      goto(257 + 64*d + 3);
      n_vec++; if (anode !== 4'hF) begin n_err++; $display("FAIL ld_blank d%0d: got %h want f", d, anode); end
      goto(257 + 64*d + 4);
      n_vec += 2;
      if (anode !== an_x[d])   begin n_err++; $display("FAIL ld_anode d%0d: got %h want %h", d, anode, an_x[d]); end
      if (segment !== sg_x[d]) begin n_err++; $display("FAIL ld_seg d%0d: got %h want %h", d, segment, sg_x[d]); end
      goto(257 + 64*d + 63);
      n_vec++; if (anode !== an_x[d]) begin n_err++; $display("FAIL ld_end d%0d: got %h want %h", d, anode, an_x[d]); end
    end
  endtask

  task automatic test_brightness;
    logic [3:0] an_x [5];
    int         off [5];
    an_x = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hF};
    off  = '{3, 4, 19, 20, 63};
    brightness = 4'd4;
    for (int i = 0; i < 5; i++) begin
      goto(513 + off[i]);
      n_vec++; if (anode !== an_x[i]) begin n_err++; $display("FAIL br4 s%0d: got %h want %h", off[i], anode, an_x[i]); end
    end
    goto(768);
    brightness = 4'd0;
    n_vec++;
    begin
      int bad = 0;
      for (int k = 769; k <= 1024; k++) begin
        goto(k);
        if (anode !== 4'hF) bad++;
      end
      if (bad != 0) begin n_err++; $display("FAIL br0_dark: %0d lit cycles, want 0", bad); end
    end
    brightness = 4'd15;
  endtask

  task automatic test_back_to_back;
    goto(1030);
    load = 1'b1; data = 16'hAAAA; en = 4'hF; dot = 4'h0;
    goto(1031);
    load = 1'b0;
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL b2b_pend: got %b want 1", pending); end
    goto(1040);
    load = 1'b1; data = 16'h5555;
    goto(1041);
    load = 1'b0;
    goto(1280);
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL b2b_clear: got %b want 0", pending); end
    for (int d = 0; d < 2; d++) begin
      goto(1285 + 64*d);
      n_vec += 2;
      if (anode !== ~(4'd1 << d)) begin n_err++; $display("FAIL b2b_anode d%0d: got %h want %h", d, anode, ~(4'd1 << d)); end
      if (segment !== 8'h92)      begin n_err++; $display("FAIL b2b_seg d%0d: got %h want 92", d, segment); end
    end
  endtask

  task automatic test_boundary_en;
    logic [3:0] an_x [4];
    logic [7:0] sg_x [4];
    an_x = '{4'hE, 4'hD, 4'hB, 4'h7};
    sg_x = '{8'hFF, 8'h80, 8'hFF, 8'h80};
    goto(1535);
    load = 1'b1; data = 16'h8888; en = 4'b1010; dot = 4'h0;
    goto(1536);
    load = 1'b0;
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL bnd_pend: got %b want 0", pending); end
    for (int d = 0; d < 4; d++) begin
      goto(1541 + 64*d);
      n_vec += 3;
      if (anode !== an_x[d])   begin n_err++; $display("FAIL en_anode d%0d: got %h want %h", d, anode, an_x[d]); end
      if (segment !== sg_x[d]) begin n_err++; $display("FAIL en_seg d%0d: got %h want %h", d, segment, sg_x[d]); end
      if (pending !== 1'b0)    begin n_err++; $display("FAIL bnd_pend d%0d: got %b want 0", d, pending); end
    end
  endtask

`ifdef SEG_DISP_BLINK_EN
  task automatic test_blink;
    int         fr [5];
    logic [3:0] an_x [5];
    fr   = '{8, 15, 16, 31, 32};
    an_x = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hE};
    goto(1791);
    load = 1'b1; data = 16'h8888; en = 4'hF; dot = 4'h0; blink = 4'b0001;
    goto(1792);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      goto(256*fr[i] + 5);
      n_vec++; if (anode !== an_x[i]) begin n_err++; $display("FAIL blink_d0 f%0d: got %h want %h", fr[i], anode, an_x[i]); end
      goto(256*fr[i] + 69);
      n_vec += 2;
      if (anode !== 4'hD)    begin n_err++; $display("FAIL blink_d1 f%0d: got %h want d", fr[i], anode); end
      if (segment !== 8'h80) begin n_err++; $display("FAIL blink_d1seg f%0d: got %h want 80", fr[i], segment); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_load;
    test_brightness;
    test_back_to_back;
    test_boundary_en;
`ifdef SEG_DISP_BLINK_EN
    test_blink;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seg_disp_scan.md
Name: seg_disp_scan

Overview:
- Parametrised multiplexed 7-segment display driver for N digit tubes on the board-device layer.
- Adds the following over the fixed 4-digit driver:
  - per-slot blanking against ghosting;
  - 4-bit PWM brightness;
  - configurable anode/segment polarity;
  - frame-synchronous double-buffered data update with load/pending handshake.
- Sits between CPU-side display registers and the board tube pins.

Parameters:
- DIGITS, 4, number of tubes scanned (1..16).
- SLOT_WIDTH, 16, log2 of clock cycles per digit slot (≥5).
- AN_ACTIVE, 1'b0, anode level that lights a tube.
- SEG_ACTIVE, 1'b0, segment/dot level that lights a segment.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle request to update displayed content.
- data  in  4*DIGITS  hex nibble per digit; digit i = data[4i+3:4i].
- en  in  DIGITS  per-digit enable, latched with data.
- dot  in  DIGITS  per-digit decimal point, latched with data.
- brightness  in  4  duty level; 0 = dark, 15 = max.
- pending  out  1  high while a loaded value awaits frame boundary.
- frame_start  out  1  one-cycle pulse when digit 0 slot begins.
- segment  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE.
- anode  out  DIGITS  one-hot at AN_ACTIVE while lit, else all inactive.

Behaviour:
- Reset is asynchronous on rst_n low. Values while and after reset:
  - slot_cnt = 0, digit index = 0;
  - shadow data/en/dot = 0;
  - pending = 0, frame_start = 0;
  - anode = all ~AN_ACTIVE;
  - segment = all ~SEG_ACTIVE.
- First lit cycle can occur only after leaving phase 0.
- slot_cnt (SLOT_WIDTH bits) increments every cycle.
  - On wrap, digit index advances 0..DIGITS-1 and then wraps to 0 (non-power-of-2 DIGITS supported; no dead slots).
- phase = slot_cnt[SLOT_WIDTH-1 -: 4].
  - Digit lit iff phase != 0 and phase <= brightness.
  - Phase 0 is mandatory blanking: anodes inactive for 2^(SLOT_WIDTH-4) cycles per slot.
  - brightness is sampled live each cycle; a mid-slot change applies immediately.
- Lit digit i output:
  - anode bit i = AN_ACTIVE, others inactive;
  - segment[6:0] = hex decode of shadow nibble i (0-F, standard a..g map, e.g. 0 -> a..f on, 8 -> all on, F -> a,e,f,g on) if en[i], else all off;
  - segment[7] = dot[i].
- Unlit cycles: anode all inactive, segment all inactive.
- Outputs are registered: one cycle latency from slot_cnt/phase/shadow to pins.
- Update handshake:
  - load=1 captures data/en/dot into a pending buffer and sets pending.
  - At the frame boundary (slot_cnt wraps from last digit to digit 0), shadow <= pending buffer and pending clears.
  - load during pending overwrites the buffer (last write wins).
  - load in the same cycle as the boundary: the new inputs go straight to shadow, pending stays 0.
- frame_start pulses in the first cycle of digit 0 slot (slot_cnt==0, index==0), registered with the outputs.
- Tearing impossible: shadow changes only at the frame boundary.

Optional Feature:
- SEG_DISP_BLINK_EN defined:
  - adds input blink [DIGITS-1:0] (latched with data) and an internal 5-bit frame counter;
  - digits with blink=1 are forced dark while frame counter bit 4 = 1 (16 frames on, 16 off);
  - counter resets to 0.
- Undefined: no blink port, no counter, behaviour as above.

Test Plan:
- Bench configuration for all scenarios: DIGITS=4, SLOT_WIDTH=6, SEG/AN_ACTIVE=0.
- Reset mid-scan: assert rst_n=0 at slot_cnt=37 -> same cycle anode=4'b1111, segment=8'hFF; after release, slot_cnt/index=0 and first anode low not before cycle 5.
- load data=16'h1234, en=4'hF, dot=4'b0100, brightness=15 -> pending=1 until boundary. Next frame shows:
  - anode 1110 with segments for 4;
  - 1101 with 3;
  - 1011 with 2 and dp low;
  - 0111 with 1.
  - Each digit is dark for 4 cycles, then lit 60 cycles.
- brightness=4 -> each slot: 4 blank, 16 lit, 44 dark; brightness=0 -> anode never active.
- Two loads (16'hAAAA then 16'h5555) inside one frame -> only 5555 displayed next frame. Load exactly on the boundary cycle -> shown in that frame, pending never rises.
- en=4'b1010 with data 16'h8888 -> digits 1,3 show 8 (segment=8'h80 w/o dot); digits 0,2 anode pulses with segment=8'hFF.
- With SEG_DISP_BLINK_EN, blink=4'b0001 -> digit 0 dark for frames 16..31, lit for frames 0..15 and 32..47; other digits unaffected.
